// File: rtl/u_wb_buf_if.sv
// Bus bundle for the register-writeback buffer: execute push, LSU fill,
// hazard advance, forwarding read ports and regfile write port.
interface u_wb_buf_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3,
  parameter int NRP   = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                 push_e;
  logic                 push_ld;
  logic [4:0]           push_a;
  logic [XLEN-1:0]      push_d;
  logic                 flush;
  logic                 adv;
  logic                 ld_vld;
  logic [XLEN-1:0]      ld_d;
  logic [NRP*5-1:0]     rd_a;
  logic [NRP*XLEN-1:0]  rd_o;
  logic [NRP-1:0]       rd_hit;
  logic [NRP-1:0]       rd_nodat;
  logic                 blk;
  logic                 ld_orph;
  logic [CW-1:0]        pend_cnt;
  logic                 rf_rd_e;
  logic [4:0]           rf_rd_a;
  logic [XLEN-1:0]      rf_rd_i;

  modport master (
    output push_e, push_ld, push_a, push_d, flush, adv, ld_vld, ld_d, rd_a,
    input  rd_o, rd_hit, rd_nodat, blk, ld_orph, pend_cnt, rf_rd_e, rf_rd_a, rf_rd_i
  );

  modport slave (
    input  push_e, push_ld, push_a, push_d, flush, adv, ld_vld, ld_d, rd_a,
    output rd_o, rd_hit, rd_nodat, blk, ld_orph, pend_cnt, rf_rd_e, rf_rd_a, rf_rd_i
  );
endinterface

// File: rtl/u_wb_buf.sv
// In-order writeback shift buffer with forwarding; load entries are
// allocated empty and filled by LSU return data, freezing retirement meanwhile.
module u_wb_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 3,
  parameter int NRP   = 2
) (
  input logic       clk,
  input logic       rst,
  u_wb_buf_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            vld_q [DEPTH];
  logic            rdy_q [DEPTH];
  logic [4:0]      a_q   [DEPTH];
  logic [XLEN-1:0] d_q   [DEPTH];
  logic            vld_n [DEPTH];
  logic            rdy_n [DEPTH];
  logic [4:0]      a_n   [DEPTH];
  logic [XLEN-1:0] d_n   [DEPTH];

  logic orph_q;
  logic blk;
  logic shift;
  logic push_ok;
  logic fill_any;
  int   fill_idx;
  int   fill_tgt;

  assign blk     = vld_q[DEPTH-1] & ~rdy_q[DEPTH-1];
  assign shift   = bus.adv & ~blk;
  assign push_ok = bus.push_e & ~bus.flush & (bus.push_a != 5'd0);

  always_comb begin
    fill_any = 1'b0;
    fill_idx = 0;
    // Later (older) pending entries overwrite earlier ones: the oldest wins.
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !rdy_q[i]) begin
        fill_any = 1'b1;
        fill_idx = i;
      end
    end
    // A pending oldest entry blocks the shift, so idx+1 never runs off the end.
    fill_tgt = shift ? fill_idx + 1 : fill_idx;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld_n[i] = vld_q[i];
      rdy_n[i] = rdy_q[i];
      a_n[i]   = a_q[i];
      d_n[i]   = d_q[i];
    end
    if (shift) begin
      for (int i = 1; i < DEPTH; i++) begin
        vld_n[i] = vld_q[i-1];
        rdy_n[i] = rdy_q[i-1];
        a_n[i]   = a_q[i-1];
        d_n[i]   = d_q[i-1];
      end
      vld_n[0] = push_ok;
      rdy_n[0] = push_ok & ~bus.push_ld;
      a_n[0]   = push_ok ? bus.push_a : 5'd0;
      d_n[0]   = (push_ok && !bus.push_ld) ? bus.push_d : '0;
    end
    if (bus.ld_vld && fill_any) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == fill_tgt) begin
          rdy_n[i] = 1'b1;
          d_n[i]   = bus.ld_d;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        rdy_q[i] <= 1'b0;
        a_q[i]   <= 5'd0;
        d_q[i]   <= '0;
      end
      orph_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_q[i] <= vld_n[i];
        rdy_q[i] <= rdy_n[i];
        a_q[i]   <= a_n[i];
        d_q[i]   <= d_n[i];
      end
      orph_q <= bus.ld_vld & ~fill_any;
    end
  end

  always_comb begin
    bus.rd_o     = '0;
    bus.rd_hit   = '0;
    bus.rd_nodat = '0;
    for (int p = 0; p < NRP; p++) begin
      if (bus.rd_a[5*p +: 5] != 5'd0) begin
        // Scan oldest to youngest so the youngest match is left standing.
        for (int i = DEPTH - 1; i >= 0; i--) begin
          if (vld_q[i] && a_q[i] == bus.rd_a[5*p +: 5]) begin
            bus.rd_hit[p]          = rdy_q[i];
            bus.rd_nodat[p]        = ~rdy_q[i];
            bus.rd_o[XLEN*p +: XLEN] = rdy_q[i] ? d_q[i] : '0;
          end
        end
      end
    end
  end

  always_comb begin
    bus.pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.pend_cnt = bus.pend_cnt + CW'(vld_q[i]);
    end
  end

  assign bus.blk     = blk;
  assign bus.ld_orph = orph_q;
  assign bus.rf_rd_e = vld_q[DEPTH-1] & rdy_q[DEPTH-1] & bus.adv;
  assign bus.rf_rd_a = bus.rf_rd_e ? a_q[DEPTH-1] : 5'd0;
  assign bus.rf_rd_i = bus.rf_rd_e ? d_q[DEPTH-1] : '0;
endmodule

// File: tb/tb_u_wb_buf.sv
// Bench for u_wb_buf: per-cycle vector table with a writeback scoreboard,
// plus a mid-operation reset sequence on a DEPTH=4, NRP=3 instance.
module tb_u_wb_buf;
  logic clk;
  logic rst;
  logic rst4;

  u_wb_buf_if #(.XLEN(32), .DEPTH(3), .NRP(2)) bus ();
  u_wb_buf_if #(.XLEN(32), .DEPTH(4), .NRP(3)) bus4 ();

  u_wb_buf #(.XLEN(32), .DEPTH(3), .NRP(2)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  u_wb_buf #(.XLEN(32), .DEPTH(4), .NRP(3)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        pe, pl;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        fl, adv, lv;
    logic [31:0] ld;
    logic [4:0]  r0, r1;
    logic [31:0] wd;
    logic [1:0]  pend;
    logic        blk, orph;
    logic [1:0]  hit, nod;
    logic [31:0] o0, o1;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t vec[$];
  wr_t  sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_wr   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic row(input logic pe, input logic pl, input logic [4:0] pa, input logic [31:0] pd,
                     input logic fl, input logic adv, input logic lv, input logic [31:0] ld,
                     input logic [4:0] r0, input logic [4:0] r1, input logic [31:0] wd,
                     input logic [1:0] pend, input logic blk, input logic orph,
                     input logic [1:0] hit, input logic [1:0] nod,
                     input logic [31:0] o0, input logic [31:0] o1);
    vec_t v;
    v.pe = pe; v.pl = pl; v.pa = pa; v.pd = pd; v.fl = fl; v.adv = adv; v.lv = lv;
    v.ld = ld; v.r0 = r0; v.r1 = r1; v.wd = wd; v.pend = pend; v.blk = blk;
    v.orph = orph; v.hit = hit; v.nod = nod; v.o0 = o0; v.o1 = o1;
    vec.push_back(v);
  endtask

  // Regfile write monitor: each retirement must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rf_rd_e) begin
        n_wr++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rf_unexpected: got a=%0d d=%0h expected no write", bus.rf_rd_a, bus.rf_rd_i);
        end else begin
          wr_t w;
          w = sb.pop_front();
          chk("rf_rd_a", 64'(bus.rf_rd_a), 64'(w.a));
          chk("rf_rd_i", 64'(bus.rf_rd_i), 64'(w.d));
        end
      end else begin
        chk("rf_idle_a", 64'(bus.rf_rd_a), 64'd0);
        chk("rf_idle_i", 64'(bus.rf_rd_i), 64'd0);
      end
    end
  end

  initial begin
    //   pe pl pa  pd        fl adv lv ld         r0 r1 wd       | pend blk orph hit    nod    o0       o1
    row(1, 0, 5,  32'h11,   0, 1, 0, 0,          5, 7, 32'h11,    0, 0, 0, 2'b00, 2'b00, 0,       0);
    row(1, 0, 6,  32'h22,   0, 1, 0, 0,          5, 7, 32'h22,    1, 0, 0, 2'b01, 2'b00, 32'h11,  0);
    row(1, 0, 7,  32'h33,   0, 1, 0, 0,          5, 7, 32'h33,    2, 0, 0, 2'b01, 2'b00, 32'h11,  0);
    row(0, 0, 0,  0,        0, 1, 0, 0,          5, 7, 0,         3, 0, 0, 2'b11, 2'b00, 32'h11,  32'h33);
    row(0, 0, 0,  0,        0, 1, 0, 0,          5, 7, 0,         2, 0, 0, 2'b10, 2'b00, 0,       32'h33);
    row(0, 0, 0,  0,        0, 1, 0, 0,          5, 7, 0,         1, 0, 0, 2'b10, 2'b00, 0,       32'h33);
    row(1, 0, 5,  32'hA,    0, 1, 0, 0,          5, 0, 32'hA,     0, 0, 0, 2'b00, 2'b00, 0,       0);
    row(1, 0, 5,  32'hB,    0, 1, 0, 0,          5, 0, 32'hB,     1, 0, 0, 2'b01, 2'b00, 32'hA,   0);
    row(0, 0, 0,  0,        0, 1, 0, 0,          5, 0, 0,         2, 0, 0, 2'b01, 2'b00, 32'hB,   0);
    row(0, 0, 0,  0,        0, 1, 0, 0,          5, 0, 0,         2, 0, 0, 2'b01, 2'b00, 32'hB,   0);
    row(0, 0, 0,  0,        0, 1, 0, 0,          5, 0, 0,         1, 0, 0, 2'b01, 2'b00, 32'hB,   0);
    row(1, 1, 9,  32'h55,   0, 1, 0, 0,          0, 9, 32'hDEAD,  0, 0, 0, 2'b00, 2'b00, 0,       0);
    row(0, 0, 0,  0,        0, 1, 0, 0,          0, 9, 0,         1, 0, 0, 2'b00, 2'b10, 0,       0);
    row(0, 0, 0,  0,        0, 1, 0, 0,          0, 9, 0,         1, 0, 0, 2'b00, 2'b10, 0,       0);
    row(1, 0, 10, 32'h77,   0, 1, 0, 0,          0, 9, 32'h77,    1, 1, 0, 2'b00, 2'b10, 0,       0);
    row(0, 0, 0,  0,        0, 1, 1, 32'hDEAD,   0, 9, 0,         1, 1, 0, 2'b00, 2'b10, 0,       0);
    row(0, 0, 0,  0,        0, 1, 0, 0,          0, 9, 0,         1, 0, 0, 2'b10, 2'b00, 0,       32'hDEAD);
    row(1, 1, 3,  0,        0, 1, 0, 0,          3, 4, 32'h1,     0, 0, 0, 2'b00, 2'b00, 0,       0);
    row(1, 1, 4,  0,        0, 1, 0, 0,          3, 4, 32'h2,     1, 0, 0, 2'b00, 2'b01, 0,       0);
    row(0, 0, 0,  0,        0, 1, 1, 32'h1,      3, 4, 0,         2, 0, 0, 2'b00, 2'b11, 0,       0);
    row(0, 0, 0,  0,        0, 0, 1, 32'h2,      3, 4, 0,         2, 0, 0, 2'b01, 2'b10, 32'h1,   0);
    row(0, 0, 0,  0,        0, 1, 0, 0,          3, 4, 0,         2, 0, 0, 2'b11, 2'b00, 32'h1,   32'h2);
    row(0, 0, 0,  0,        0, 1, 0, 0,          3, 4, 0,         1, 0, 0, 2'b10, 2'b00, 0,       32'h2);
    row(1, 0, 8,  32'h88,   1, 1, 0, 0,          8, 0, 32'h88,    0, 0, 0, 2'b00, 2'b00, 0,       0);
    row(0, 0, 0,  0,        0, 1, 1, 32'h99,     8, 0, 0,         0, 0, 0, 2'b00, 2'b00, 0,       0);
    row(0, 0, 0,  0,        0, 1, 0, 0,          8, 0, 0,         0, 0, 1, 2'b00, 2'b00, 0,       0);
    row(0, 0, 0,  0,        0, 1, 0, 0,          8, 0, 0,         0, 0, 0, 2'b00, 2'b00, 0,       0);

    rst  = 1'b1;
    rst4 = 1'b1;
    bus.push_e = 1'b1; bus.push_ld = 1'b0; bus.push_a = 5'd5; bus.push_d = 32'h1;
    bus.flush = 1'b0; bus.adv = 1'b1; bus.ld_vld = 1'b1; bus.ld_d = 32'h5;
    bus.rd_a = {5'd7, 5'd5};
    bus4.push_e = 1'b0; bus4.push_ld = 1'b0; bus4.push_a = 5'd0; bus4.push_d = 32'h0;
    bus4.flush = 1'b0; bus4.adv = 1'b0; bus4.ld_vld = 1'b0; bus4.ld_d = 32'h0;
    bus4.rd_a = '0;

    #3;
    repeat (2) @(posedge clk);
    #2;
    chk("rst pend_cnt", 64'(bus.pend_cnt), 64'd0);
    chk("rst rf_rd_e",  64'(bus.rf_rd_e),  64'd0);
    chk("rst rd_hit",   64'(bus.rd_hit),   64'd0);
    chk("rst rd_nodat", 64'(bus.rd_nodat), 64'd0);
    chk("rst rd_o",     64'(bus.rd_o),     64'd0);
    chk("rst blk",      64'(bus.blk),      64'd0);
    chk("rst ld_orph",  64'(bus.ld_orph),  64'd0);

    bus.push_e = 1'b0; bus.ld_vld = 1'b0; bus.adv = 1'b0;
    @(negedge clk);
    rst  = 1'b0;
    rst4 = 1'b0;
    @(posedge clk);
    #1;

    foreach (vec[i]) begin
      bus.push_e = vec[i].pe; bus.push_ld = vec[i].pl; bus.push_a = vec[i].pa;
      bus.push_d = vec[i].pd; bus.flush = vec[i].fl;   bus.adv = vec[i].adv;
      bus.ld_vld = vec[i].lv; bus.ld_d = vec[i].ld;    bus.rd_a = {vec[i].r1, vec[i].r0};
      if (vec[i].pe && !vec[i].fl && vec[i].pa != 5'd0 && vec[i].adv && !vec[i].blk)
        sb.push_back('{a: vec[i].pa, d: vec[i].wd});
      @(negedge clk);
      chk($sformatf("r%0d pend_cnt", i), 64'(bus.pend_cnt), 64'(vec[i].pend));
      chk($sformatf("r%0d blk", i),      64'(bus.blk),      64'(vec[i].blk));
      chk($sformatf("r%0d ld_orph", i),  64'(bus.ld_orph),  64'(vec[i].orph));
      chk($sformatf("r%0d rd_hit", i),   64'(bus.rd_hit),   64'(vec[i].hit));
      chk($sformatf("r%0d rd_nodat", i), 64'(bus.rd_nodat), 64'(vec[i].nod));
      chk($sformatf("r%0d rd_o0", i),    64'(bus.rd_o[31:0]),  64'(vec[i].o0));
      chk($sformatf("r%0d rd_o1", i),    64'(bus.rd_o[63:32]), 64'(vec[i].o1));
      @(posedge clk);
      #1;
    end
    bus.push_e = 1'b0; bus.ld_vld = 1'b0; bus.adv = 1'b0; bus.rd_a = '0;

    chk("sb drained", 64'(sb.size()), 64'd0);
    chk("rf writes",  64'(n_wr),      64'd8);

    // Mid-operation reset with a pending load on the wider instance.
    bus4.adv = 1'b1;
    bus4.push_e = 1'b1; bus4.push_ld = 1'b1; bus4.push_a = 5'd12; bus4.push_d = 32'h0;
    @(posedge clk);
    #1;
    bus4.push_ld = 1'b0; bus4.push_a = 5'd13; bus4.push_d = 32'h44;
    @(posedge clk);
    #1;
    bus4.push_e = 1'b0; bus4.adv = 1'b0;
    bus4.rd_a = {5'd13, 5'd12, 5'd0};
    #2;
    chk("d4 pre pend_cnt", 64'(bus4.pend_cnt), 64'd2);
    chk("d4 pre rd_nodat", 64'(bus4.rd_nodat), 64'b010);
    chk("d4 pre rd_hit",   64'(bus4.rd_hit),   64'b100);
    chk("d4 pre rd_o2",    64'(bus4.rd_o[95:64]), 64'h44);
    rst4 = 1'b1;
    #1;
    chk("d4 rst pend_cnt", 64'(bus4.pend_cnt), 64'd0);
    chk("d4 rst rd_nodat", 64'(bus4.rd_nodat), 64'd0);
    chk("d4 rst rd_hit",   64'(bus4.rd_hit),   64'd0);
    chk("d4 rst rd_o",     64'(|bus4.rd_o),    64'd0);
    chk("d4 rst blk",      64'(bus4.blk),      64'd0);
    chk("d4 rst rf_rd_e",  64'(bus4.rf_rd_e),  64'd0);
    rst4 = 1'b0;
    #1;
    bus4.ld_vld = 1'b1; bus4.ld_d = 32'h123;
    @(posedge clk);
    #1;
    bus4.ld_vld = 1'b0;
    chk("d4 ld_orph pulse", 64'(bus4.ld_orph),  64'd1);
    chk("d4 post pend_cnt", 64'(bus4.pend_cnt), 64'd0);
    @(posedge clk);
    #1;
    chk("d4 ld_orph clear", 64'(bus4.ld_orph), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/u_wb_buf.md
Name: u_wb_buf

Overview:
- Parametrised register-writeback buffer with forwarding. It is the successor to the fixed 3-entry write buffer inside the execute stage.
- DEPTH-entry in-order shift pipeline between execute and the regfile write port.
- NRP forwarding read ports.
- Load entries are allocated before their data exists and are filled later by LSU return data. Instead of only flagging missing data, the block fills the entry and stalls retirement until the data arrives.
- Sits between the execute unit, the LSU response path, the hazard unit and the regfile.

Parameters:
- XLEN, 32, data width.
- DEPTH, 3, buffer entries (>=2).
- NRP, 2, forwarding read ports (>=1).

Ports:
- clk  in  1  clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- push_e  in  1  execute result entering the buffer this cycle.
- push_ld  in  1  pushed entry is a load; data not yet present.
- push_a  in  5  destination register.
- push_d  in  XLEN  result data; ignored when push_ld=1.
- flush  in  1  squash this cycle's push.
- adv  in  1  pipeline advance enable from the hazard unit.
- ld_vld  in  1  LSU load data valid.
- ld_d  in  XLEN  LSU load data.
- rd_a  in  NRP*5  forwarding source register addresses; port p uses bits [5p+4:5p].
- rd_o  out  NRP*XLEN  forwarded data for each port.
- rd_hit  out  NRP  matching entry found with data present.
- rd_nodat  out  NRP  youngest matching entry is a load still waiting for data.
- blk  out  1  oldest entry is a pending load; buffer frozen.
- ld_orph  out  1  one-cycle pulse: ld_vld arrived with no pending load entry.
- pend_cnt  out  $clog2(DEPTH+1)  number of valid entries.
- rf_rd_e  out  1  regfile write enable.
- rf_rd_a  out  5  regfile write address.
- rf_rd_i  out  XLEN  regfile write data.

Behaviour:
- Entry fields: vld, rdy, a[4:0], d[XLEN-1:0]. Entry 0 is youngest; entry DEPTH-1 is oldest.
- Reset: all entries vld=0, rdy=0, a=0, d=0.
- Output values during reset: rf_rd_e=0, rd_hit=0, rd_nodat=0, blk=0, ld_orph=0, pend_cnt=0, rd_o=0.
- blk = e[DEPTH-1].vld & !e[DEPTH-1].rdy. This is combinational.
- Shift happens when adv & !blk:
  - e[i] <= e[i-1] for i >= 1.
  - e[0] <= push entry if push_e & !flush & push_a!=0; otherwise e[0] <= empty.
  - The old e[DEPTH-1] is discarded after retiring.
- No shift (adv=0 or blk=1): all entries hold. The push is dropped; the hazard unit must keep the producer stalled.
- Push entry contents: vld=1, rdy=!push_ld, a=push_a, d = push_ld ? 0 : push_d.
- Retire (combinational): rf_rd_e = e[DEPTH-1].vld & e[DEPTH-1].rdy & adv. Then rf_rd_a = e[DEPTH-1].a and rf_rd_i = e[DEPTH-1].d. When rf_rd_e=0, rf_rd_a and rf_rd_i are 0.
- Load fill:
  - On ld_vld, the oldest entry with vld & !rdy gets d <= ld_d and rdy <= 1.
  - Index is computed on the pre-shift state. If a shift happens in the same cycle, the fill lands on that entry's post-shift position.
  - A fill of e[DEPTH-1] in a cycle where blk=1 clears blk next cycle. The fill does not retire in the same cycle.
  - ld_vld with no pending load: no state change; ld_orph=1 for that cycle, registered, so it is visible the next cycle.
- Forwarding, per port p, combinational:
  - rd_a[p]==0 gives hit=0, nodat=0, rd_o=0.
  - Otherwise, scan entries 0 to DEPTH-1 and take the first (youngest) with vld & a==rd_a[p].
  - If that entry is rdy: rd_hit=1, rd_o = its d.
  - If it is not rdy: rd_nodat=1, rd_hit=0, rd_o=0.
  - No match: both flags 0, rd_o=0.
  - Same-cycle push and same-cycle ld fill are not bypassed; they become visible the next cycle.
- pend_cnt = popcount(e[*].vld), registered state.
- Entries with push_a==0 are never allocated.
- Asserting rst mid-operation clears all entries immediately. Pending loads are lost; any later ld_vld produces ld_orph.

Test Plan:
- Reset, then push a=5 d=0x11, a=6 d=0x22, a=7 d=0x33 with adv=1 → rf_rd_e pulses in order (5,0x11), (6,0x22), (7,0x33) in cycles 3,4,5 after the first push; pend_cnt peaks at 3.
- Push a=5 d=0xA then a=5 d=0xB, rd_a[0]=5 → rd_o[0]=0xB, rd_hit[0]=1 (youngest wins); after the first retires, rd_o[0] stays 0xB.
- Push load a=9, rd_a[1]=9 → rd_nodat[1]=1. After two shifts blk=1 and the buffer holds. ld_vld with ld_d=0xDEAD → next cycle blk=0, rd_hit[1]=1, rd_o=0xDEAD, then rf_rd_e writes (9,0xDEAD).
- Two loads a=3 and a=4 pending, two ld_vld pulses 0x1 then 0x2 → a=3 gets 0x1 and a=4 gets 0x2 (in-order fill).
- flush=1 with push_e=1 a=8 → no entry allocated, pend_cnt unchanged, no rf write for 8. ld_vld with no pending load → ld_orph=1 for one cycle.
- Assert rst while a load is pending and DEPTH=4, NRP=3 → all outputs 0 immediately; a subsequent ld_vld gives ld_orph=1.
